// File: rtl/sigmoid_pla_pipe.sv
// sigmoid_pla_pipe: 3-stage piecewise-linear sigmoid approximation.
// Programmable {grad, off} segment table, valid/ready output handshake.
module sigmoid_pla_pipe #(
  parameter int BITS      = 16,
  parameter int FRAC      = 8,
  parameter int SEGS      = 8,
  parameter int SEG_SHIFT = 8,
  localparam int AW       = $clog2(SEGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] alfa,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [BITS-1:0] cfg_grad,
  input  logic [BITS-1:0] cfg_off
);

  localparam int PW = 2 * BITS;
  localparam int SW = PW + 1;
  localparam logic [BITS-1:0] ONE  = BITS'(1) << FRAC;
  localparam logic [BITS-1:0] MINN = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] MAXP = {1'b0, {(BITS-1){1'b1}}};

  logic [BITS-1:0] grad_t [SEGS];
  logic [BITS-1:0] off_t  [SEGS];

  logic            advance;
  logic            v1, v2, v3;
  logic [BITS-1:0] mag1, grad1, off1;
  logic            neg1, oor1;
  logic [PW-1:0]   prod2;
  logic [BITS-1:0] off2;
  logic            neg2, oor2;

  logic [BITS-1:0] mag;
  logic [BITS-1:0] idx_w;
  logic            oor;
  logic [AW-1:0]   seg;
  logic [PW-1:0]   ps;
  logic [SW-1:0]   sum;
  logic [BITS-1:0] y;
  logic [BITS-1:0] res;

  assign advance   = !v3 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3;

  // Magnitude with the most-negative input pinned to max positive
  always_comb begin
    mag = x;
    if (x[BITS-1]) begin
      if (x == MINN) mag = MAXP;
      else           mag = -x;
    end
  end

  assign idx_w = mag >> SEG_SHIFT;
  assign oor   = idx_w >= BITS'(SEGS);
  assign seg   = idx_w[AW-1:0];

  // Offset add, clamp to ONE, then mirror for negative inputs
  always_comb begin
    ps  = prod2 >> FRAC;
    sum = {1'b0, ps} + SW'(off2);
    y   = sum[BITS-1:0];
    if (oor2 || sum > SW'(ONE)) y = ONE;
    res = neg2 ? ONE - y : y;
  end

  // Coefficient table; writes ignore pipeline stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEGS; i++) begin
        grad_t[i] <= '0;
        off_t[i]  <= '0;
      end
    end else if (cfg_we) begin
      grad_t[cfg_addr] <= cfg_grad;
      off_t[cfg_addr]  <= cfg_off;
    end
  end

  // Stage valid bits shift together on advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // S1: magnitude, sign, range flag and table read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag1  <= '0;
      grad1 <= '0;
      off1  <= '0;
      neg1  <= 1'b0;
      oor1  <= 1'b0;
    end else if (advance) begin
      mag1  <= mag;
      grad1 <= grad_t[seg];
      off1  <= off_t[seg];
      neg1  <= x[BITS-1];
      oor1  <= oor;
    end
  end

  // S2: full-width product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod2 <= '0;
      off2  <= '0;
      neg2  <= 1'b0;
      oor2  <= 1'b0;
    end else if (advance) begin
      prod2 <= PW'(mag1) * PW'(grad1);
      off2  <= off1;
      neg2  <= neg1;
      oor2  <= oor1;
    end
  end

  // S3: result register feeding alfa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alfa <= '0;
    end else if (advance && v2) begin
      alfa <= res;
    end
  end

endmodule
